// File: rtl/lsu_align_if.sv
// Request, data-memory and load-result signals between the EX stage, lsu_align and the data memory.
interface lsu_align_if;
  localparam int unsigned AddrW = 11;
  localparam int unsigned DataW = 32;

  logic             req_valid;
  logic [2:0]       req_op;
  logic             req_unsigned;
  logic [AddrW-1:0] req_addr;
  logic [DataW-1:0] req_wdata;
  logic             pipe_hold;
  logic [2:0]       mem_op;
  logic [AddrW-1:0] mem_addr;
  logic [DataW-1:0] mem_wdata;
  logic             mem_stall;
  logic [DataW-1:0] mem_rdata;
  logic             busy;
  logic             ld_valid;
  logic [DataW-1:0] ld_data;
  logic             misalign;

  modport master (
    output req_valid, req_op, req_unsigned, req_addr, req_wdata, pipe_hold, mem_rdata,
    input  mem_op, mem_addr, mem_wdata, mem_stall, busy, ld_valid, ld_data, misalign
  );

  modport slave (
    input  req_valid, req_op, req_unsigned, req_addr, req_wdata, pipe_hold, mem_rdata,
    output mem_op, mem_addr, mem_wdata, mem_stall, busy, ld_valid, ld_data, misalign
  );
endinterface

// File: rtl/lsu_align.sv
// Load/store alignment unit between EX and a word-read, byte-addressed data memory.
// Misaligned halfword/word accesses are split into byte accesses when MISALIGN_SPLIT_EN is defined.
module lsu_align (
  input  logic       clk,
  input  logic       nrst,
  lsu_align_if.slave bus
);
  localparam int unsigned AddrW = 11;
  localparam int unsigned DataW = 32;

  localparam logic [2:0] OpStoreByte = 3'b000;
  localparam logic [2:0] OpLoadWord  = 3'b110;
  localparam logic [1:0] SzByte      = 2'd0;
  localparam logic [1:0] SzHalf      = 2'd1;

`ifdef MISALIGN_SPLIT_EN
  localparam bit SplitEn = 1'b1;
`else
  localparam bit SplitEn = 1'b0;
`endif

  typedef enum logic {IDLE = 1'b0, SPLIT = 1'b1} state_e;

  state_e           state_q, state_d;
  logic [1:0]       cnt_q, cnt_d;
  logic [1:0]       size_q, size_d;
  logic             load_q, load_d;
  logic             uns_q, uns_d;
  logic [AddrW-1:0] base_q, base_d;
  logic [AddrW-1:0] addr_q, addr_d;
  logic [DataW-1:0] wdata_q, wdata_d;
  logic [DataW-1:0] asm_q, asm_d;
  logic [1:0]       lane_q, lane_d;
  logic             ld_pend_q, ld_pend_d;
  logic             zero_pend_q, zero_pend_d;
  logic             fin_pend_q, fin_pend_d;
  logic             mis_q, mis_d;

  logic             accept;
  logic             req_load;
  logic             req_mis;
  logic             issue;
  logic [1:0]       req_size;
  logic [1:0]       last_idx;
  logic [1:0]       cap_idx;
  logic [2:0]       op_c;
  logic [AddrW-1:0] iss_addr;
  logic [DataW-1:0] wd_c;
  logic [DataW-1:0] assembled;
  logic [DataW-1:0] raw;
  logic [DataW-1:0] ld_c;
  logic [7:0]       rd_byte;
  logic [15:0]      rd_half;

  // lane_q is the byte offset of the address issued last cycle, i.e. of the word now on mem_rdata
  assign rd_byte = bus.mem_rdata[{lane_q, 3'b000} +: 8];
  assign rd_half = lane_q[1] ? bus.mem_rdata[31:16] : bus.mem_rdata[15:0];

  always_ff @(posedge clk) begin
    if (!nrst) begin
      state_q     <= IDLE;
      cnt_q       <= 2'd0;
      size_q      <= 2'd0;
      load_q      <= 1'b0;
      uns_q       <= 1'b0;
      base_q      <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      asm_q       <= '0;
      lane_q      <= 2'd0;
      ld_pend_q   <= 1'b0;
      zero_pend_q <= 1'b0;
      fin_pend_q  <= 1'b0;
      mis_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      size_q      <= size_d;
      load_q      <= load_d;
      uns_q       <= uns_d;
      base_q      <= base_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      asm_q       <= asm_d;
      lane_q      <= lane_d;
      ld_pend_q   <= ld_pend_d;
      zero_pend_q <= zero_pend_d;
      fin_pend_q  <= fin_pend_d;
      mis_q       <= mis_d;
    end
  end

  // Acceptance, issue to memory and split sequencing
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    size_d      = size_q;
    load_d      = load_q;
    uns_d       = uns_q;
    base_d      = base_q;
    wdata_d     = wdata_q;
    asm_d       = asm_q;
    addr_d      = addr_q;
    lane_d      = lane_q;
    ld_pend_d   = 1'b0;
    zero_pend_d = 1'b0;
    fin_pend_d  = 1'b0;
    mis_d       = 1'b0;
    issue       = 1'b0;
    op_c        = OpLoadWord;
    iss_addr    = addr_q;
    wd_c        = '0;

    req_size = bus.req_op[1:0];
    req_load = bus.req_op[2];
    req_mis  = ((req_size == SzHalf) && bus.req_addr[0]) ||
               (req_size[1] && (bus.req_addr[1:0] != 2'b00));
    accept   = bus.req_valid && !bus.pipe_hold && (state_q == IDLE);
    last_idx = (size_q == SzHalf) ? 2'd1 : 2'd3;
    cap_idx  = cnt_q - 2'd1;

    case (state_q)
      IDLE: begin
        if (accept) begin
          size_d  = req_size;
          load_d  = req_load;
          uns_d   = bus.req_unsigned;
          base_d  = bus.req_addr;
          wdata_d = bus.req_wdata;
          mis_d   = req_mis;
          if (!req_mis) begin
            issue     = 1'b1;
            iss_addr  = bus.req_addr;
            op_c      = req_load ? OpLoadWord : bus.req_op;
            wd_c      = req_load ? '0 : bus.req_wdata;
            ld_pend_d = req_load;
          end else if (SplitEn) begin
            issue    = 1'b1;
            iss_addr = bus.req_addr;
            op_c     = req_load ? OpLoadWord : OpStoreByte;
            wd_c     = req_load ? '0 : {24'h0, bus.req_wdata[7:0]};
            cnt_d    = 2'd1;
            state_d  = SPLIT;
          end else begin
            zero_pend_d = req_load;
          end
        end
      end
      SPLIT: begin
        issue    = 1'b1;
        iss_addr = base_q + AddrW'(cnt_q);
        op_c     = load_q ? OpLoadWord : OpStoreByte;
        wd_c     = load_q ? '0 : {24'h0, wdata_q[{cnt_q, 3'b000} +: 8]};
        if (load_q) begin
          asm_d[{cap_idx, 3'b000} +: 8] = rd_byte;
        end
        cnt_d = cnt_q + 2'd1;
        if (cnt_q == last_idx) begin
          state_d    = IDLE;
          fin_pend_d = load_q;
        end
      end
      default: state_d = IDLE;
    endcase

    if (!nrst) begin
      issue = 1'b0;
    end
    if (issue) begin
      addr_d = iss_addr;
      lane_d = iss_addr[1:0];
    end
  end

  // Load result: lane extraction or split assembly, then sign/zero extension
  always_comb begin
    assembled = asm_q;
    if (size_q == SzHalf) begin
      assembled[15:8] = rd_byte;
    end else begin
      assembled[31:24] = rd_byte;
    end

    raw = bus.mem_rdata;
    if (fin_pend_q) begin
      raw = assembled;
    end else if (size_q == SzByte) begin
      raw = {24'h0, rd_byte};
    end else if (size_q == SzHalf) begin
      raw = {16'h0, rd_half};
    end

    case (size_q)
      SzByte:  ld_c = {{24{raw[7] & ~uns_q}}, raw[7:0]};
      SzHalf:  ld_c = {{16{raw[15] & ~uns_q}}, raw[15:0]};
      default: ld_c = raw;
    endcase

    if (!nrst || zero_pend_q || !(ld_pend_q || fin_pend_q)) begin
      ld_c = '0;
    end
  end

  assign bus.mem_op    = issue ? op_c : OpLoadWord;
  assign bus.mem_addr  = !nrst ? '0 : (issue ? iss_addr : addr_q);
  assign bus.mem_wdata = issue ? wd_c : '0;
  assign bus.mem_stall = ~issue;
  assign bus.busy      = (state_q == SPLIT);
  assign bus.ld_valid  = ld_pend_q | zero_pend_q | fin_pend_q;
  assign bus.ld_data   = ld_c;
  assign bus.misalign  = mis_q;

endmodule

// File: tb/tb_lsu_align.sv
// Directed bench for lsu_align with a byte-array data memory and a load-result scoreboard.
module tb_lsu_align;
  localparam logic [2:0] SB = 3'b000;
  localparam logic [2:0] SH = 3'b001;
  localparam logic [2:0] SW = 3'b010;
  localparam logic [2:0] LB = 3'b100;
  localparam logic [2:0] LH = 3'b101;
  localparam logic [2:0] LW = 3'b110;

  logic        clk = 1'b0;
  logic        nrst;
  int          checks = 0;
  int          errors = 0;
  logic [7:0]  mem [0:2047];
  logic [31:0] exp_q [$];
  logic [31:0] exp_v;
  logic [10:0] tb_wa;
  int          tb_nb;

  lsu_align_if bus ();

  lsu_align dut (
    .clk  (clk),
    .nrst (nrst),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  // Data memory: word read returned next cycle, byte-granular writes
  always @(posedge clk) begin
    if (bus.mem_stall === 1'b0) begin
      if (bus.mem_op[2]) begin
        tb_wa = {bus.mem_addr[10:2], 2'b00};
        bus.mem_rdata <= {mem[tb_wa + 11'd3], mem[tb_wa + 11'd2], mem[tb_wa + 11'd1], mem[tb_wa]};
      end else begin
        tb_nb = (bus.mem_op[1:0] == 2'd0) ? 1 : (bus.mem_op[1:0] == 2'd1) ? 2 : 4;
        for (int i = 0; i < tb_nb; i++) begin
          mem[11'(bus.mem_addr + 11'(i))] = bus.mem_wdata[8*i +: 8];
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every ld_valid pops the oldest expected load result
  always @(negedge clk) begin
    if (bus.ld_valid === 1'b1) begin
      checks++;
      assert (exp_q.size() != 0) else begin
        errors++;
        $error("FAIL ld_spurious observed=%08h expected=no_load", bus.ld_data);
      end
      if (exp_q.size() != 0) begin
        exp_v = exp_q.pop_front();
        checks++;
        assert (bus.ld_data === exp_v) else begin
          errors++;
          $error("FAIL ld_data observed=%08h expected=%08h", bus.ld_data, exp_v);
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic req(input logic [2:0] op, input logic uns, input logic [10:0] a, input logic [31:0] wd);
    bus.req_valid    = 1'b1;
    bus.req_op       = op;
    bus.req_unsigned = uns;
    bus.req_addr     = a;
    bus.req_wdata    = wd;
  endtask

  task automatic idle();
    bus.req_valid = 1'b0;
    bus.req_op    = LW;
    bus.req_addr  = 11'h000;
    bus.req_wdata = 32'h0;
  endtask

  initial begin
    for (int i = 0; i < 2048; i++) mem[i] = 8'h00;
    mem[11'h006] = 8'h80;
    mem[11'h008] = 8'h11; mem[11'h009] = 8'h22; mem[11'h00A] = 8'h33; mem[11'h00B] = 8'h44;
    mem[11'h00C] = 8'h78; mem[11'h00D] = 8'h9A;
    nrst = 1'b0;
    bus.pipe_hold = 1'b0;
    req(LB, 1'b0, 11'h123, 32'hFFFFFFFF);

    // reset, with a request presented that must not reach memory
    cyc(); cyc();
    smp();
    chk("rst_stall", 32'(bus.mem_stall), 32'd1);
    chk("rst_op", 32'(bus.mem_op), 32'(LW));
    chk("rst_addr", 32'(bus.mem_addr), 32'h0);
    chk("rst_wdata", bus.mem_wdata, 32'h0);
    chk("rst_ld_data", bus.ld_data, 32'h0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_ldv", 32'(bus.ld_valid), 32'd0);
    chk("rst_mis", 32'(bus.misalign), 32'd0);
    cyc(); nrst = 1'b1; idle();
    smp();
    chk("idle_stall", 32'(bus.mem_stall), 32'd1);

    // aligned loads, back to back
    cyc(); req(LB, 1'b0, 11'h006, 32'h0); exp_q.push_back(32'hFFFFFF80);
    smp();
    chk("lb_stall", 32'(bus.mem_stall), 32'd0);
    chk("lb_op", 32'(bus.mem_op), 32'(LW));
    chk("lb_addr", 32'(bus.mem_addr), 32'h006);
    cyc(); req(LB, 1'b1, 11'h006, 32'h0); exp_q.push_back(32'h00000080);
    smp();
    chk("lb_ldv", 32'(bus.ld_valid), 32'd1);
    chk("lb_mis", 32'(bus.misalign), 32'd0);
    chk("lbu_stall", 32'(bus.mem_stall), 32'd0);
    cyc(); req(LH, 1'b0, 11'h00C, 32'h0); exp_q.push_back(32'hFFFF9A78);
    cyc(); req(LH, 1'b1, 11'h00A, 32'h0); exp_q.push_back(32'h00004433);
    cyc(); req(LW, 1'b0, 11'h008, 32'h0); exp_q.push_back(32'h44332211);

    // aligned stores
    cyc(); req(SW, 1'b0, 11'h010, 32'hCAFEF00D);
    smp();
    chk("sw_op", 32'(bus.mem_op), 32'(SW));
    chk("sw_addr", 32'(bus.mem_addr), 32'h010);
    chk("sw_wdata", bus.mem_wdata, 32'hCAFEF00D);
    chk("sw_stall", 32'(bus.mem_stall), 32'd0);
    cyc(); req(SB, 1'b0, 11'h013, 32'h123456A5);
    smp();
    chk("sb_wdata", bus.mem_wdata, 32'h123456A5);
    chk("sb_op", 32'(bus.mem_op), 32'(SB));
    cyc(); idle();
    smp();
    chk("hold_addr", 32'(bus.mem_addr), 32'h013);
    chk("hold_stall", 32'(bus.mem_stall), 32'd1);
    chk("hold_op", 32'(bus.mem_op), 32'(LW));
    chk("hold_wdata", bus.mem_wdata, 32'h0);
    chk("st_no_ldv", 32'(bus.ld_valid), 32'd0);
    cyc(); req(LW, 1'b0, 11'h010, 32'h0); exp_q.push_back(32'hA5FEF00D);
    cyc(); req(LB, 1'b0, 11'h013, 32'h0); exp_q.push_back(32'hFFFFFFA5);

    // pipe_hold blocks acceptance
    cyc(); bus.pipe_hold = 1'b1; req(LW, 1'b0, 11'h008, 32'h0);
    smp();
    chk("ph_stall", 32'(bus.mem_stall), 32'd1);
    cyc(); bus.pipe_hold = 1'b0; idle();
    smp();
    chk("ph_ldv", 32'(bus.ld_valid), 32'd0);

`ifdef MISALIGN_SPLIT_EN
    // word load wrapping 0x7FF -> 0x000, pipe_hold high during the split
    mem[11'h7FF] = 8'h11; mem[11'h000] = 8'h22; mem[11'h001] = 8'h33; mem[11'h002] = 8'h44;
    cyc(); req(LW, 1'b0, 11'h7FF, 32'h0); exp_q.push_back(32'h44332211);
    smp();
    chk("w0_addr", 32'(bus.mem_addr), 32'h7FF);
    chk("w0_op", 32'(bus.mem_op), 32'(LW));
    chk("w0_busy", 32'(bus.busy), 32'd0);
    cyc(); idle(); bus.pipe_hold = 1'b1;
    smp();
    chk("w1_addr", 32'(bus.mem_addr), 32'h000);
    chk("w1_busy", 32'(bus.busy), 32'd1);
    chk("w1_mis", 32'(bus.misalign), 32'd1);
    chk("w1_stall", 32'(bus.mem_stall), 32'd0);
    cyc(); smp();
    chk("w2_addr", 32'(bus.mem_addr), 32'h001);
    chk("w2_ldv", 32'(bus.ld_valid), 32'd0);
    chk("w2_mis", 32'(bus.misalign), 32'd0);
    cyc(); smp();
    chk("w3_addr", 32'(bus.mem_addr), 32'h002);
    chk("w3_busy", 32'(bus.busy), 32'd1);
    cyc(); smp();
    chk("w4_ldv", 32'(bus.ld_valid), 32'd1);
    chk("w4_busy", 32'(bus.busy), 32'd0);
    chk("w4_stall", 32'(bus.mem_stall), 32'd1);
    bus.pipe_hold = 1'b0;

    // halfword across the 1023/1024 boundary; request while busy is ignored
    mem[11'h3FF] = 8'h34; mem[11'h400] = 8'h12; mem[11'h020] = 8'h5A;
    cyc(); req(LH, 1'b0, 11'h3FF, 32'h0); exp_q.push_back(32'h00001234);
    smp();
    chk("h0_addr", 32'(bus.mem_addr), 32'h3FF);
    cyc(); req(LB, 1'b0, 11'h020, 32'h0);
    smp();
    chk("h1_addr", 32'(bus.mem_addr), 32'h400);
    chk("h1_busy", 32'(bus.busy), 32'd1);
    chk("h1_op", 32'(bus.mem_op), 32'(LW));
    cyc(); req(LB, 1'b0, 11'h3FF, 32'h0); exp_q.push_back(32'h00000034);
    smp();
    chk("h2_ldv", 32'(bus.ld_valid), 32'd1);
    chk("h2_busy", 32'(bus.busy), 32'd0);
    chk("h2_addr", 32'(bus.mem_addr), 32'h3FF);
    chk("h2_stall", 32'(bus.mem_stall), 32'd0);
    cyc(); idle();
    smp();
    chk("h3_ldv", 32'(bus.ld_valid), 32'd1);
    cyc(); smp();
    chk("h4_ldv", 32'(bus.ld_valid), 32'd0);

    // misaligned word store split into bytes
    cyc(); req(SW, 1'b0, 11'h001, 32'hDEADBEEF);
    smp();
    chk("s0_op", 32'(bus.mem_op), 32'(SB));
    chk("s0_addr", 32'(bus.mem_addr), 32'h001);
    chk("s0_byte", 32'(bus.mem_wdata[7:0]), 32'h0EF);
    chk("s0_busy", 32'(bus.busy), 32'd0);
    cyc(); idle();
    smp();
    chk("s1_op", 32'(bus.mem_op), 32'(SB));
    chk("s1_addr", 32'(bus.mem_addr), 32'h002);
    chk("s1_byte", 32'(bus.mem_wdata[7:0]), 32'h0BE);
    chk("s1_busy", 32'(bus.busy), 32'd1);
    chk("s1_mis", 32'(bus.misalign), 32'd1);
    cyc(); smp();
    chk("s2_addr", 32'(bus.mem_addr), 32'h003);
    chk("s2_byte", 32'(bus.mem_wdata[7:0]), 32'h0AD);
    chk("s2_busy", 32'(bus.busy), 32'd1);
    cyc(); smp();
    chk("s3_addr", 32'(bus.mem_addr), 32'h004);
    chk("s3_byte", 32'(bus.mem_wdata[7:0]), 32'h0DE);
    chk("s3_busy", 32'(bus.busy), 32'd1);
    cyc(); smp();
    chk("s4_busy", 32'(bus.busy), 32'd0);
    chk("s4_stall", 32'(bus.mem_stall), 32'd1);

    // read the split store back, then a signed split halfword
    mem[11'h021] = 8'h80; mem[11'h022] = 8'hF0;
    cyc(); req(LW, 1'b0, 11'h001, 32'h0); exp_q.push_back(32'hDEADBEEF);
    cyc(); idle();
    cyc(); cyc();
    cyc(); req(LH, 1'b0, 11'h021, 32'h0); exp_q.push_back(32'hFFFFF080);
    smp();
    chk("rb_ldv", 32'(bus.ld_valid), 32'd1);
    cyc(); idle();
    cyc(); smp();
    chk("sh_ldv", 32'(bus.ld_valid), 32'd1);

    // reset in the middle of a 4-byte split load
    cyc(); req(LW, 1'b0, 11'h041, 32'h0);
    cyc(); idle();
    smp();
    chk("r1_busy", 32'(bus.busy), 32'd1);
    cyc(); nrst = 1'b0;
    smp();
    chk("r2_stall", 32'(bus.mem_stall), 32'd1);
    chk("r2_addr", 32'(bus.mem_addr), 32'h0);
    cyc(); nrst = 1'b1;
    smp();
    chk("r3_busy", 32'(bus.busy), 32'd0);
    chk("r3_ldv", 32'(bus.ld_valid), 32'd0);
    chk("r3_stall", 32'(bus.mem_stall), 32'd1);
    cyc(); smp();
    chk("r4_ldv", 32'(bus.ld_valid), 32'd0);
    chk("r4_stall", 32'(bus.mem_stall), 32'd1);
`else
    // misaligned accesses are accepted but never issued
    cyc(); req(LW, 1'b0, 11'h002, 32'h0); exp_q.push_back(32'h00000000);
    smp();
    chk("n0_stall", 32'(bus.mem_stall), 32'd1);
    chk("n0_busy", 32'(bus.busy), 32'd0);
    cyc(); idle();
    smp();
    chk("n1_ldv", 32'(bus.ld_valid), 32'd1);
    chk("n1_mis", 32'(bus.misalign), 32'd1);
    chk("n1_busy", 32'(bus.busy), 32'd0);
    chk("n1_stall", 32'(bus.mem_stall), 32'd1);
    cyc(); req(SH, 1'b0, 11'h005, 32'h0000BEEF);
    smp();
    chk("n2_stall", 32'(bus.mem_stall), 32'd1);
    cyc(); idle();
    smp();
    chk("n3_mis", 32'(bus.misalign), 32'd1);
    chk("n3_busy", 32'(bus.busy), 32'd0);
    chk("n3_ldv", 32'(bus.ld_valid), 32'd0);
    cyc(); smp();
    chk("n4_mis", 32'(bus.misalign), 32'd0);
`endif

    cyc(); cyc();
    chk("sb_empty", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/lsu_align.md
LSU_ALIGN -- requirements
Module: lsu_align

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-low reset, with all state updated on the rising edge of clk.
REQ-002 clk  input  1  single clock.
REQ-003 nrst  input  1  synchronous active-low reset.
REQ-004 req_valid  input  1  EX-stage access request.
REQ-005 req_op  input  3  mem.vh code: LoadByte, LoadHalfWord, LoadWord, StoreByte, StoreHalfWord or StoreWord; bit2=0 means store.
REQ-006 req_unsigned  input  1  zero-extend load result (LBU/LHU).
REQ-007 req_addr  input  11  byte address.
REQ-008 req_wdata  input  32  store data, little-endian.
REQ-009 pipe_hold  input  1  pipeline freeze; no new request is accepted while high.
REQ-010 mem_op  output  3  op code driven to the data memory.
REQ-011 mem_addr  output  11  address driven to the data memory.
REQ-012 mem_wdata  output  32  write data driven to the data memory.
REQ-013 mem_stall  output  1  1 = data memory disabled this cycle.
REQ-014 mem_rdata  input  32  data-memory read word, valid the cycle after issue.
REQ-015 busy  output  1  split sequence in progress; upstream holds off.
REQ-016 ld_valid  output  1  load result valid this cycle.
REQ-017 ld_data  output  32  extended load result.
REQ-018 misalign  output  1  one-cycle pulse, registered, in the cycle after a misaligned request is accepted.

Function
REQ-019 A request SHALL be accepted in cycle T when req_valid=1, pipe_hold=0, and the FSM is IDLE.
REQ-020 Aligned access SHALL mean: any byte access; a halfword with addr[0]=0; a word with addr[1:0]=0.
REQ-021 An aligned store SHALL be issued in cycle T as follows: mem_op=req_op, mem_addr=req_addr, mem_wdata=req_wdata, mem_stall=0; there is no further activity.
REQ-022 An aligned load SHALL be issued in cycle T as follows: mem_op=LoadWord, mem_addr=req_addr, mem_stall=0.
REQ-023 For an aligned load, ld_valid SHALL be 1 in T+1.
REQ-024 For an aligned load, ld_data SHALL be extracted in T+1 from mem_rdata using the offset registered at T: byte mem_rdata[8*off+7:8*off]; halfword selected by off[1]; word unchanged.
REQ-025 The extracted load value SHALL be sign-extended, or zero-extended when req_unsigned=1.
REQ-026 FSM states SHALL be IDLE and SPLIT.
REQ-027 A misaligned accepted request SHALL cause IDLE->SPLIT, with N=2 for a halfword and N=4 for a word.
REQ-028 In SPLIT, byte k (k=0..N-1) SHALL be issued in cycle T+k at address (req_addr+k) mod 2048; k=0 is issued combinationally in T.
REQ-029 For a split store, byte k SHALL be issued with mem_op=StoreByte and mem_wdata[7:0]=req_wdata[8k+7:8k].
REQ-030 For a split load, byte k SHALL be issued with mem_op=LoadWord, and the addressed byte of mem_rdata SHALL be captured in T+k+1.
REQ-031 busy SHALL be 1 in cycles T+1..T+N-1; SPLIT->IDLE after byte N-1 is issued.
REQ-032 A split load SHALL assert ld_valid in T+N with the assembled, extended value; its final byte is taken combinationally from mem_rdata.
REQ-033 A new request SHALL be acceptable in the same cycle as any ld_valid.
REQ-034 Requests presented while busy=1 SHALL be ignored and not accepted.
REQ-035 pipe_hold SHALL NOT pause SPLIT; a split sequence always completes, and ld_valid is never delayed by pipe_hold.
REQ-036 When nothing is issued, the block SHALL drive mem_stall=1, mem_op=LoadWord, mem_addr held, mem_wdata=0.
REQ-037 Byte addresses crossing 1023->1024 SHALL need no special handling; the bank change is transparent.

Reset
REQ-038 With nrst=0 at a rising edge, the block SHALL enter IDLE, and busy, ld_valid and misalign SHALL all read 0.
REQ-039 While nrst=0, mem_stall SHALL be 1, mem_op SHALL be LoadWord, and mem_addr, mem_wdata and ld_data SHALL be 0.
REQ-040 Reset mid-SPLIT SHALL abort the sequence; no further bytes are issued and no ld_valid is produced.

Configuration
REQ-041 With MISALIGN_SPLIT_EN defined, misaligned accesses SHALL be split per REQ-027..REQ-032.
REQ-042 Without MISALIGN_SPLIT_EN, a misaligned request SHALL still be accepted but not issued (mem_stall=1), SHALL still raise misalign, SHALL never assert busy, and a misaligned load SHALL return ld_valid=1 with ld_data=0 in T+1.

Verification
REQ-043 The bench SHALL cover: LoadByte at addr 0x006 with req_unsigned=0, mem word 0x00800000 -> T+1 ld_valid=1, ld_data=0xFFFFFF80.
REQ-044 The bench SHALL cover: StoreWord 0xDEADBEEF at 0x001 with split enabled -> StoreByte EF@0x001, BE@0x002, AD@0x003, DE@0x004 in T..T+3; busy=1 in T+1..T+3; misalign=1 in T+1.
REQ-045 The bench SHALL cover: LoadHalfWord at 0x3FF across the bank boundary, bytes 0x34@0x3FF and 0x12@0x400 -> ld_valid at T+2, ld_data=0x00001234.
REQ-046 The bench SHALL cover: LoadWord at 0x7FF (wrap), bytes 11,22,33,44 at 0x7FF,0x000,0x001,0x002 -> T+4 ld_data=0x44332211.
REQ-047 The bench SHALL cover: nrst=0 at T+2 of a 4-byte split -> T+3 IDLE, busy=0, no ld_valid, mem_stall=1.
REQ-048 The bench SHALL cover: macro undefined, LoadWord at 0x002 -> mem_stall=1 in T, T+1 ld_valid=1, ld_data=0, misalign=1, busy=0 throughout.
